// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared state encoding and access-size constants for the memory port scheduler.
package mem_sched_pkg;
  typedef enum logic [2:0] {
    FETCH,
    IWAIT,
    EXEC,
    DWAIT,
    DDONE,
    HALT
  } state_t;
  localparam logic [1:0] EXT_WORD = 2'b00;
  localparam logic [1:0] EXT_BYTE = 2'b01;
  localparam logic [1:0] EXT_HALF = 2'b10;
endpackage

// File: rtl/mem_align_chk.sv
// mem_align_chk: flags a data address that is not naturally aligned for its access size.
module mem_align_chk
  import mem_sched_pkg::*;
(
  input  logic [1:0] dm_ext,
  input  logic [1:0] dm_addr,
  output logic       misaligned
);
  // size code 3 falls through to the word rule
  always_comb
    misaligned = (dm_ext == EXT_BYTE) ? 1'b0 :
                 (dm_ext == EXT_HALF) ? dm_addr[0] : |dm_addr;
endmodule

// File: rtl/mem_port_sched.sv
// mem_port_sched: shares one single-ported synchronous RAM between instruction fetch and
// data load/store, including the read half of sub-word store read-modify-write.
module mem_port_sched
  import mem_sched_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  input  logic          dm_re,
  input  logic          dm_we,
  input  logic [1:0]    dm_ext,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          pc_en,
  output logic          err,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);
  state_t      r_state, w_next;
  logic [31:0] r_instr, r_rdata;
  logic        r_err;
  logic        w_mis_raw, w_access, w_mis, w_word, w_word_st, w_exec, w_ddone;
  logic        w_unused;
  mem_align_chk u_align (
    .dm_ext    (dm_ext),
    .dm_addr   (dm_addr[1:0]),
    .misaligned(w_mis_raw)
  );
  assign w_access  = dm_re | dm_we;
  assign w_mis     = w_access & w_mis_raw;
  assign w_word    = (dm_ext != EXT_BYTE) && (dm_ext != EXT_HALF);
  assign w_word_st = dm_we & w_word;
  assign w_exec    = (r_state == EXEC);
  assign w_ddone   = (r_state == DDONE);
  assign w_unused  = ^{pc[31:AW+2], pc[1:0], dm_addr[31:AW+2]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_instr <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IWAIT) r_instr <= ram_rdata;
      if (r_state == DWAIT) r_rdata <= ram_rdata;
      if (w_exec && w_mis) r_err <= 1'b1;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   w_next = IWAIT;
      IWAIT:   w_next = EXEC;
      EXEC:    w_next = w_mis ? HALT : (!w_access || w_word_st) ? FETCH : DWAIT;
      DWAIT:   w_next = DDONE;
      DDONE:   w_next = FETCH;
      default: w_next = HALT;
    endcase
  end
  // reset gates every strobe so an aborted RMW never writes
  always_comb begin
    pc_en     = !rst && ((w_exec && !w_mis && (!w_access || w_word_st)) || w_ddone);
    ram_we    = !rst && ((w_exec && !w_mis && w_word_st) || (w_ddone && dm_we));
    ram_en    = !rst && ((r_state == FETCH) || (w_exec && w_access && !w_mis) || (w_ddone && dm_we));
    ram_addr  = (r_state == FETCH) ? pc[AW+1:2] : dm_addr[AW+1:2];
    ram_wdata = dm_wdata;
    instr     = r_instr;
    dm_rdata  = r_rdata;
    err       = r_err;
  end
endmodule

// File: tb/tb_mem_port_sched.sv
// tb_mem_port_sched: randomized instruction stream against a byte-addressed memory model,
// plus directed reset, misalignment and aborted-RMW scenarios.
module tb_mem_port_sched;
  localparam int AW = 10;
  localparam int WORDS = 1 << AW;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   pc = '0, dm_addr = '0, st_data = '0;
  logic          dm_re = 1'b0, dm_we = 1'b0;
  logic [1:0]    dm_ext = '0;
  logic [31:0]   dm_wdata, instr, dm_rdata, ram_wdata, ram_rdata;
  logic          pc_en, err, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram [WORDS];
  logic [7:0]    model [WORDS*4];
  int            errors = 0, checks = 0;
  always #5 clk = ~clk;
  mem_port_sched #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .dm_re(dm_re), .dm_we(dm_we),
    .dm_ext(dm_ext), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .pc_en(pc_en), .err(err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) ram[ram_addr] = ram_wdata;
      else ram_rdata <= ram[ram_addr];
    end
  // datapath store extension: splice the new byte/half into the word read back
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] v,
                                        input logic [1:0] ext, input logic [1:0] a);
    logic [4:0] sh;
    if (ext == 2'd1) begin
      sh = {a, 3'b000};
      return (old & ~(32'hFF << sh)) | ((v & 32'hFF) << sh);
    end
    if (ext == 2'd2) begin
      sh = {a[1], 4'b0000};
      return (old & ~(32'hFFFF << sh)) | ((v & 32'hFFFF) << sh);
    end
    return v;
  endfunction
  assign dm_wdata = merge(dm_rdata, st_data, dm_ext, dm_addr[1:0]);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mword(input logic [31:0] a);
    int b;
    b = int'({a[11:2], 2'b00});
    return {model[b+3], model[b+2], model[b+1], model[b]};
  endfunction
  task automatic set_word(input int i, input logic [31:0] v);
    ram[i] = v;
    for (int j = 0; j < 4; j++) model[i*4+j] = v[8*j+:8];
  endtask
  task automatic mstore(input logic [31:0] a, input logic [1:0] ext, input logic [31:0] v);
    int b;
    b = int'(a[11:0]);
    if (ext == 2'd1) model[b] = v[7:0];
    else if (ext == 2'd2) for (int j = 0; j < 2; j++) model[(b & ~1) + j] = v[8*j+:8];
    else for (int j = 0; j < 4; j++) model[(b & ~3) + j] = v[8*j+:8];
  endtask
  // kind: 0 = no memory op, 1 = load, 2 = store, 3 = load+store (store wins)
  task automatic do_instr(input int kind, input logic [31:0] addr, input logic [1:0] ext,
                          input logic [31:0] val, input logic [31:0] pcv);
    logic [31:0] exp_instr, exp_rd, exp_wd, wa, wd;
    int cyc, rd, wr, exp_cyc;
    bit st, sub;
    st = kind >= 2;
    sub = (ext == 2'd1) || (ext == 2'd2);
    pc = pcv; dm_re = (kind == 1) || (kind == 3); dm_we = st;
    dm_ext = ext; dm_addr = addr; st_data = val;
    exp_instr = mword(pcv);
    exp_cyc = (kind == 1 || (st && sub)) ? 5 : 3;
    exp_rd = mword(addr);
    exp_wd = '0;
    if (st) begin
      mstore(addr, ext, val);
      exp_wd = mword(addr);
    end
    cyc = 0; rd = 0; wr = 0; wa = '0; wd = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("fetch_rd", {31'b0, ram_en && !ram_we}, 32'd1);
        chk("fetch_addr", 32'(ram_addr), 32'(pcv[11:2]));
      end
      if (ram_en && !ram_we) rd++;
      if (ram_we) begin
        wr++; wa = 32'(ram_addr); wd = ram_wdata;
      end
      if (pc_en) break;
    end
    chk("cycles", cyc, exp_cyc);
    chk("reads", rd, (exp_cyc == 5) ? 2 : 1);
    chk("writes", wr, st ? 1 : 0);
    if (st) begin
      chk("wr_addr", wa, 32'(addr[11:2]));
      chk("wr_data", wd, exp_wd);
    end
    if (kind == 1) chk("load_data", dm_rdata, exp_rd);
    chk("instr", instr, exp_instr);
    @(posedge clk); #1;
  endtask
  task automatic do_misaligned(input bit re, input bit we, input logic [1:0] ext,
                               input logic [31:0] addr);
    int acc, pce, errlow;
    pc = 32'h100; dm_re = re; dm_we = we; dm_ext = ext; dm_addr = addr; st_data = 32'h1234_5678;
    acc = 0; pce = 0; errlow = 0;
    @(negedge clk);
    chk("mis_fetch", {31'b0, ram_en}, 32'd1);
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (ram_en || ram_we) acc++;
      if (pc_en) pce++;
      if (c >= 2 && !err) errlow++;
    end
    chk("halt_access", acc, 0);
    chk("halt_pc_en", pce, 0);
    chk("halt_err_low", errlow, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_clears_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    do_instr(0, 0, 0, 0, 32'h104);
  endtask
  initial begin
    logic [31:0] a;
    logic [1:0] e;
    int k, nbad;
    for (int i = 0; i < WORDS; i++) set_word(i, $urandom);
    set_word(0, 32'h0000_0000);
    set_word(4, 32'hDEAD_BEEF);
    set_word(2, 32'h1122_3344);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_en", {31'b0, pc_en}, 0);
    chk("rst_ram_en", {31'b0, ram_en}, 0);
    chk("rst_ram_we", {31'b0, ram_we}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_rdata", dm_rdata, 0);
    chk("rst_err", {31'b0, err}, 0);
    @(posedge clk); #1 rst = 1'b0;
    do_instr(0, 32'h0, 2'd0, 32'h0, 32'h0);
    do_instr(1, 32'h10, 2'd0, 32'h0, 32'h4);
    chk("load_deadbeef", dm_rdata, 32'hDEAD_BEEF);
    do_instr(2, 32'h09, 2'd1, 32'hAA, 32'h8);
    chk("rmw_word", ram[2], 32'h1122_AA44);
    do_instr(2, 32'h20, 2'd0, 32'hCAFE_F00D, 32'hC);
    chk("word_store", ram[8], 32'hCAFE_F00D);
    for (int n = 0; n < 150; n++) begin
      k = int'($urandom_range(0, 3));
      e = 2'($urandom_range(0, 3));
      a = $urandom;
      if (e == 2'd2) a[0] = 1'b0;
      else if (e != 2'd1) a[1:0] = 2'b00;
      do_instr(k, a, e, $urandom, $urandom & 32'hFFFF_FFFC);
    end
    // half store aborted by reset while waiting for its read data
    pc = 32'h200; dm_re = 1'b0; dm_we = 1'b1; dm_ext = 2'd2; dm_addr = 32'h40; st_data = 32'h5555;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ram_we) k++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (ram_we) k++;
    chk("abort_no_write", k, 0);
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_rdata", dm_rdata, 0);
    chk("abort_instr", instr, 0);
    chk("abort_ram", ram[16], mword(32'h40));
    do_instr(0, 0, 0, 0, 32'h204);
    do_misaligned(1'b1, 1'b0, 2'd0, 32'h13);
    do_misaligned(1'b0, 1'b1, 2'd2, 32'h21);
    nbad = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== mword(32'(i * 4))) nbad++;
    chk("mem_final", nbad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_sched.md
# mem_port_sched

Multi-cycle scheduler that shares one single-ported synchronous RAM between instruction fetch and data load/store for the MIPS datapath. It fetches the instruction at `pc`, holds it stable while the datapath evaluates, and issues the data access. For sub-word stores it performs the read-modify-write that the datapath's store-extension logic needs. It sits between the datapath/control unit and the unified memory. It throttles architectural commit through `pc_en`.

## Interface
- `AW`, default 10: RAM word-address width (4 KB). `ram_addr` is byte address bits `[AW+1:2]`; higher address bits are ignored and alias.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `pc` in 32: fetch byte address from the PC register.
- `instr` out 32: registered instruction to the datapath and control unit.
- `dm_re` in 1: the current instruction is a load (from the control unit).
- `dm_we` in 1: the current instruction is a store (from the control unit).
- `dm_ext` in 2: access size; 0 = word, 1 = byte, 2 = half. 3 is treated as word.
- `dm_addr` in 32: data byte address (ALU result).
- `dm_wdata` in 32: store word, already merged by the datapath's store extension.
- `dm_rdata` out 32: registered memory word to the datapath (`readdata`).
- `pc_en` out 1: commit strobe. The PC register and register-file write are enabled only when `pc_en` = 1.
- `err` out 1: sticky misaligned-access flag.
- `ram_en` out 1: RAM access enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out AW: RAM word address.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid exactly 1 cycle after a read with `ram_en` = 1 and `ram_we` = 0.

## Operation
- States: FETCH, IWAIT, EXEC, DWAIT, DDONE, HALT.
- **FETCH:** `ram_en` = 1, `ram_addr` = `pc[AW+1:2]` → IWAIT.
- **IWAIT:** `instr_q` ← `ram_rdata` → EXEC.
- **EXEC:** control inputs and `dm_addr` are now valid, derived from `instr_q`.
  - Misaligned access → HALT and set `err`. An access is misaligned if `dm_re|dm_we`, and either size is word with `dm_addr[1:0]` ≠ 0, or size is half with `dm_addr[0]` ≠ 0. No RAM access, `pc_en` = 0.
  - Neither `dm_re` nor `dm_we` → `pc_en` = 1 → FETCH.
  - Word store → `ram_en` = `ram_we` = 1, `ram_wdata` = `dm_wdata`, `pc_en` = 1 → FETCH.
  - Load, or byte/half store → read at `dm_addr[AW+1:2]` → DWAIT.
  - If `dm_re` and `dm_we` are both set, store takes priority.
- **DWAIT:** `rdata_q` ← `ram_rdata` → DDONE.
- **DDONE:** `dm_rdata` = `rdata_q`; `pc_en` = 1.
  - For a store, also `ram_en` = `ram_we` = 1 and `ram_wdata` = `dm_wdata`, which the datapath has merged from `rdata_q`.
  - → FETCH.
- **HALT:** all RAM strobes are 0 and `pc_en` = 0. Leaves only on `rst`.
- `instr` = `instr_q` and `dm_rdata` = `rdata_q` at all times; both change only in IWAIT and DWAIT respectively.
- `ram_wdata` = `dm_wdata` whenever `ram_we` = 1; don't-care otherwise.

## Timing
- Reset values: state FETCH, `instr_q` = 0 (nop), `rdata_q` = 0, `err` = 0.
- Combinational outputs during the reset cycle: `pc_en` = 0, `ram_en` = 0, `ram_we` = 0.
- The first fetch is issued in the cycle after `rst` deasserts.
- Cycles per instruction:
  - ALU, branch or jump: 3.
  - Word store: 3.
  - Load: 5.
  - Byte/half store: 5.
- `pc_en` is high for exactly 1 cycle per instruction, in the last cycle of that instruction. The PC updates on that edge.
- `rst` asserted in any state aborts the operation: no RAM write in that cycle, and a pending RMW is dropped.
- At most one RAM access per cycle; a read and a write never occur in the same cycle.
- `pc` and `instr` are stable from IWAIT+1 through the commit cycle.

## Structure
- Package `mem_sched_pkg` holds:
  - the state enum;
  - the size constants EXT_WORD = 2'b00, EXT_BYTE = 2'b01, EXT_HALF = 2'b10, shared with the control unit's `ext` encoding.
- One combinational sub-module, `mem_align_chk`, with inputs `dm_ext` and `dm_addr[1:0]` and output `misaligned`.
- The FSM, `instr_q`, `rdata_q` and `err` live in the top module.

## Test plan
- **Reset then ALU op.**
  - Stimulus: `rst` 1 cycle, RAM[0] = 0x00000000, no memory access.
  - Required: fetch at `ram_addr` 0 one cycle after reset; `instr` = 0 in EXEC; a single `pc_en` pulse 3 cycles after the fetch.
- **Load word.**
  - Stimulus: RAM[4] = 0xDEADBEEF, `dm_re` = 1, `dm_addr` = 0x10.
  - Required: read at `ram_addr` 4 in EXEC; `dm_rdata` = 0xDEADBEEF in DDONE; `pc_en` = 1 only in DDONE; 5 cycles total.
- **Byte store RMW.**
  - Stimulus: RAM[2] = 0x11223344, `dm_we` = 1, `dm_ext` = 1, `dm_addr` = 0x09, model merge writes 0xAA.
  - Required: read at 2 in EXEC; write 0x1122AA44 at 2 in DDONE with `pc_en` = 1; no other writes.
- **Word store.**
  - Stimulus: `dm_we` = 1, `dm_ext` = 0, `dm_addr` = 0x20, `dm_wdata` = 0xCAFEF00D.
  - Required: a single write to address 8 in EXEC with `pc_en` = 1; next FETCH follows.
- **Misaligned.**
  - Stimulus: `dm_re` = 1, `dm_ext` = 0, `dm_addr` = 0x13.
  - Required: `err` = 1 from the next cycle; no RAM access; `pc_en` stays 0 for 20 cycles; `rst` clears `err` and restarts at FETCH.
- **Reset mid-RMW.**
  - Stimulus: assert `rst` in DWAIT of a half store.
  - Required: `ram_we` never asserted; RAM unchanged; `rdata_q` = 0 after reset.
